keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad by driving one row low at a time and reading the column lines. Each key is debounced across full scans, then encoded as a 4-bit hex code. The result is presented on a valid/ready handshake. The block is the input-side counterpart of the multiplexed seven-segment display driver, and its optional digit register can feed that driver's 16-bit data input directly.

---
 rtl/keypad_pkg.sv | 18 +
 rtl/keypad_sync.sv | 27 ++
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the key map for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef logic [3:0] keycode_t;

    typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_t;

    typedef enum logic {RELEASED, PRESSED} state_t;

    // Indexed [row][col]; row 3 carries '*' as E and '#' as F.
    localparam keycode_t KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer; resets to all-ones, which is the idle level of
// pulled-up column lines.
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] ff1_q, ff2_q;

    // Two back-to-back stages to settle metastability on the async inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff1_q <= '1;
            ff2_q <= '1;
        end else begin
            ff1_q <= d;
            ff2_q <= ff1_q;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row scan, per-scan debounce, press/release
// FSM and valid/ready key output.
// Optional: KEYPAD_DIGIT_SHIFT_EN builds a 4-digit shift register of
// consumed keys on the digits output; otherwise digits is tied to zero.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 32768,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  rows,
    input  logic [3:0]  cols,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        key_held,
    output logic        overrun,
    output logic [15:0] digits
);

    localparam int             DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]     DEB_MAX    = 4'(DEBOUNCE_SCANS);

    logic [3:0] cols_s;

    keypad_sync #(.W(4)) u_cols_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cols),
        .q     (cols_s)
    );

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    rows_q, rows_d;
    logic [1:0]    hits_q, hits_d;      // closed keys so far this scan, saturating at 2
    keycode_t      hcode_q, hcode_d;    // first closed key seen this scan
    scan_res_t     prev_res_q, prev_res_d;
    keycode_t      prev_code_q, prev_code_d;
    logic [3:0]    stable_q, stable_d;
    state_t        state_q, state_d;
    keycode_t      key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic          overrun_q, overrun_d;

    logic [2:0]    row_hits, sum;
    keycode_t      row_code, acc_code;
    scan_res_t     res;
    logic          emit;

    // Next-state logic: scan timing, hit accumulation, debounce, FSM, handshake.
    always_comb begin
        dwell_d     = (dwell_q == DWELL_LAST) ? '0 : dwell_q + DW'(1);
        row_d       = row_q;
        hits_d      = hits_q;
        hcode_d     = hcode_q;
        prev_res_d  = prev_res_q;
        prev_code_d = prev_code_q;
        stable_d    = stable_q;
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        emit        = 1'b0;
        res         = NONE;

        // Closed keys on the currently driven row.
        row_hits = 3'd0;
        row_code = 4'h0;
        for (int c = 0; c < 4; c++) begin
            if (!cols_s[c]) begin
                if (row_hits == 3'd0) row_code = KEYMAP[row_q][c];
                row_hits = row_hits + 3'd1;
            end
        end
        sum      = {1'b0, hits_q} + row_hits;
        acc_code = (hits_q != 2'd0) ? hcode_q : row_code;

        if (dwell_q == DWELL_LAST) begin
            row_d = row_q + 2'd1;
            if (row_q == 2'd3) begin
                // End of a full scan: classify, debounce, then run the FSM.
                hits_d  = 2'd0;
                hcode_d = 4'h0;
                if (sum == 3'd0)      res = NONE;
                else if (sum == 3'd1) res = SINGLE;
                else                  res = MULTI;

                if (res == MULTI)
                    stable_d = 4'd0;
                else if (res == prev_res_q && (res == NONE || acc_code == prev_code_q))
                    stable_d = (stable_q == DEB_MAX) ? DEB_MAX : stable_q + 4'd1;
                else
                    stable_d = 4'd1;
                prev_res_d  = res;
                prev_code_d = (res == SINGLE) ? acc_code : 4'h0;

                case (state_q)
                    RELEASED: if (res == SINGLE && stable_d == DEB_MAX) begin
                        state_d = PRESSED;
                        emit    = 1'b1;
                    end
                    PRESSED:  if (res == NONE && stable_d == DEB_MAX)
                        state_d = RELEASED;
                    default:  state_d = RELEASED;
                endcase
            end else begin
                hits_d  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
                hcode_d = acc_code;
            end
        end

        rows_d = ~(4'b0001 << row_d);

        if (key_valid_q && key_ready) key_valid_d = 1'b0;
        if (emit) begin
            if (!key_valid_q || key_ready) begin
                key_code_d  = acc_code;
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        key_held_d = (state_d == PRESSED);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_q     <= '0;
            row_q       <= 2'd0;
            rows_q      <= 4'b1110;
            hits_q      <= 2'd0;
            hcode_q     <= 4'h0;
            prev_res_q  <= NONE;
            prev_code_q <= 4'h0;
            stable_q    <= 4'd0;
            state_q     <= RELEASED;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            rows_q      <= rows_d;
            hits_q      <= hits_d;
            hcode_q     <= hcode_d;
            prev_res_q  <= prev_res_d;
            prev_code_q <= prev_code_d;
            stable_q    <= stable_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rows      = rows_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;

`ifdef KEYPAD_DIGIT_SHIFT_EN
    logic [15:0] digits_q, digits_d;

    // Shift each consumed key in as the newest digit.
    always_comb begin
        digits_d = digits_q;
        if (key_valid_q && key_ready) digits_d = {digits_q[11:0], key_code_q};
    end

    // Digit history register.
    always_ff @(posedge clk) begin
        if (!rst_n) digits_q <= 16'h0000;
        else        digits_q <= digits_d;
    end

    assign digits = digits_q;
`else
    assign digits = 16'h0000;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=8, DEBOUNCE_SCANS=2 (32-cycle scan).
// Expected keys go into a queue; a monitor pops one per handshake.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b1;
    logic        key_held;
    logic        overrun;
    logic [15:0] digits;

    logic [15:0] keys = 16'h0;   // bit r*4+c set = key at (row r, col c) closed
    int          tests = 0;
    int          fails = 0;
    logic [3:0]  exp_q [$];
    logic [15:0] exp_dig;

    keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun),
        .digits    (digits)
    );

    always #5 clk = ~clk;

    // Passive keypad matrix: a closed key pulls its column to the driven row.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && keys[r*4+c]) cols[c] = 1'b0;
    end

    // Monitor: every handshake must match the oldest expected key.
    always @(negedge clk) begin
        if (rst_n && key_valid && key_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL handshake: unexpected key %0h, none expected", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    fails++;
                    $display("FAIL handshake: key_code %0h, expected %0h", key_code, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Return #1 after the edge where rows goes 0111 -> 1110 (a new scan).
    task automatic to_scan_start();
        logic [3:0] p;
        p = rows;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (rows == 4'b1110 && p == 4'b0111) return;
            p = rows;
        end
        chk("scan_align_timeout", 32'd1, 32'd0);
    endtask

    task automatic scans(input int n);
        for (int i = 0; i < n; i++) to_scan_start();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rows"},     rows,      4'b1110);
        chk({tag, "_code"},     key_code,  4'h0);
        chk({tag, "_valid"},    key_valid, 1'b0);
        chk({tag, "_held"},     key_held,  1'b0);
        chk({tag, "_overrun"},  overrun,   1'b0);
        chk({tag, "_digits"},   digits,    16'h0000);
    endtask

    // Exact press latency: key_held rises on the 64th edge after scan start.
    task automatic chk_latency(input string tag, input logic [3:0] code);
        repeat (63) @(posedge clk);
        #1;
        chk({tag, "_held_early"}, key_held, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_held"},  key_held,  1'b1);
        chk({tag, "_valid"}, key_valid, 1'b1);
        chk({tag, "_code"},  key_code,  code);
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, key_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_dig = 16'h0;
        // 1. Reset and row rotation
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        for (int i = 1; i < 40; i++) begin
            logic [3:0] er;
            @(posedge clk); #1;
            er = ~(4'b0001 << ((i / 8) % 4));
            chk("rotate_rows", {key_valid, rows}, {1'b0, er});
        end

        // 2. Single press of key 6 (row 1, col 2)
        to_scan_start();
        keys = 16'h0040;
        exp_q.push_back(4'h6);
        chk_latency("press6", 4'h6);
`ifdef KEYPAD_DIGIT_SHIFT_EN
        exp_dig = 16'h0006;
`endif
        chk("press6_digits", digits, exp_dig);
        keys = 16'h0;
        scans(3);
        chk("release6_held", key_held, 1'b0);

        // 3. Bounce on key 5, then a clean hold
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'h0020 : 16'h0;
            to_scan_start();
        end
        chk("bounce_held", key_held, 1'b0);
        exp_q.push_back(4'h5);
        keys = 16'h0020;
        scans(2);
        #20;
        chk("hold5_held", key_held, 1'b1);
        keys = 16'h0;
        scans(3);

        // 4. Overrun: 3 pending, 9 dropped
        key_ready = 1'b0;
        exp_q.push_back(4'h3);
        keys = 16'h0004;
        scans(2);
        keys = 16'h0;
        scans(3);
        chk("ovr_first", overrun, 1'b0);
        keys = 16'h0400;
        scans(2);
        keys = 16'h0;
        scans(3);
        chk("ovr_code",    key_code,  4'h3);
        chk("ovr_valid",   key_valid, 1'b1);
        chk("ovr_overrun", overrun,   1'b1);
        key_ready = 1'b1;
        @(posedge clk); #1;
        chk("ovr_valid_clr", key_valid, 1'b0);
        chk("ovr_sticky",    overrun,   1'b1);
`ifdef KEYPAD_DIGIT_SHIFT_EN
        exp_dig = 16'h0653;
`endif
        chk("ovr_digits", digits, exp_dig);

        // 5. Multi-key, then rollover 1 -> 2
        keys = 16'h0003;
        scans(3);
        chk("multi_held", key_held, 1'b0);
        exp_q.push_back(4'h1);
        keys = 16'h0001;
        scans(2);
        #20;
        chk("roll1_held", key_held, 1'b1);
        chk("roll1_code", key_code, 4'h1);
        keys = 16'h0002;
        scans(3);
        chk("roll2_held", key_held, 1'b1);
        chk("roll2_code", key_code, 4'h1);
        keys = 16'h0;
        scans(3);
        chk("roll_release", key_held, 1'b0);
`ifdef KEYPAD_DIGIT_SHIFT_EN
        exp_dig = 16'h6531;
`endif
        chk("roll_digits", digits, exp_dig);

        // 6. Reset during the 2nd scan of a press of key 0 (row 3, col 1)
        to_scan_start();
        keys = 16'h2000;
        to_scan_start();
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset("midreset");
        rst_n = 1'b1;
        exp_q.push_back(4'h0);
        chk_latency("press0", 4'h0);
        keys = 16'h0;
        scans(3);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
